// File: rtl/uart_tx_arbiter_pkg.sv
// Shared constants and types for the UART transmit arbiter.
// Contents: clock/baud constants, the derived minimum byte time, the FSM state enum
// and an index-width helper.
package uart_tx_arbiter_pkg;

    localparam int unsigned SYS_CLK_HZ = 100_000_000;
    localparam int unsigned BAUD       = 115200;
    localparam int unsigned FRAME_BITS = 11;

    // Smallest legal byte time in system clocks (rounded up): 9549 at 100 MHz / 115200.
    localparam int unsigned BYTE_CYCLES_MIN = (SYS_CLK_HZ * FRAME_BITS + BAUD - 1) / BAUD;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_GAP   = 2'd2
    } state_e;

    // Width of an index into n requesters, never less than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Byte-producer bus shared by NUM_REQ requesters and the arbiter.
// Signals: req_valid / req_data (byte i at [8i+7:8i]) / req_last driven by the producers,
// req_ready (one-hot) driven by the arbiter. master = producers, slave = arbiter.
interface uart_tx_arbiter_if #(
    parameter int unsigned NUM_REQ = 4
);
    logic [NUM_REQ-1:0]   req_valid;
    logic [8*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]   req_last;
    logic [NUM_REQ-1:0]   req_ready;

    modport master (
        output req_valid,
        output req_data,
        output req_last,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_data,
        input  req_last,
        output req_ready
    );
endinterface

// File: rtl/uart_tx_arbiter_rr.sv
// Round-robin picker: first requester after last_ptr (circularly) whose req and mask bits are set.
// Ports: req, mask, last_ptr in; grant_c (one-hot), idx_c, found_c out (all combinational).
module rr_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter  int unsigned NUM_REQ = 4,
    localparam int unsigned IDX_W   = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] mask,
    input  logic [IDX_W-1:0]   last_ptr,
    output logic [NUM_REQ-1:0] grant_c,
    output logic [IDX_W-1:0]   idx_c,
    output logic               found_c
);

    logic [IDX_W-1:0] pos;

    // Scan starts one past the previous winner, so the previous winner comes last.
    always_comb begin
        grant_c = '0;
        idx_c   = '0;
        found_c = 1'b0;
        pos     = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            pos = IDX_W'((32'(last_ptr) + k) % NUM_REQ);
            if (!found_c && req[pos] && mask[pos]) begin
                found_c      = 1'b1;
                idx_c        = pos;
                grant_c[pos] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter among NUM_REQ byte producers with round-robin arbitration,
// packet lock (with idle timeout) and fixed byte-time pacing of the write strobe.
// Ports: sys_clk_i, sys_rst_ni (sync, active-low); req (slave side of the requester bus,
// req_ready is combinational); uart_wr_o one-cycle strobe, uart_dat_o byte held until the
// next accept, grant_o one-hot owner of the last byte, busy_o high in ISSUE and GAP.
// BYTE_CYCLES must be at least 3; real UART use needs >= BYTE_CYCLES_MIN.
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ      = 4,
    parameter int unsigned BYTE_CYCLES  = 9600,
    parameter int unsigned LOCK_TIMEOUT = 65535
) (
    input  logic               sys_clk_i,
    input  logic               sys_rst_ni,
    uart_tx_arbiter_if.slave   req,
    output logic               uart_wr_o,
    output logic [7:0]         uart_dat_o,
    output logic [NUM_REQ-1:0] grant_o,
    output logic               busy_o
);

    localparam int unsigned IDX_W = idx_width(NUM_REQ);
    localparam int unsigned GAP_W = $clog2(BYTE_CYCLES);
    localparam int unsigned TO_W  = $clog2(LOCK_TIMEOUT + 2);

    state_e             state;
    logic [GAP_W-1:0]   gap_cnt;
    logic [TO_W-1:0]    to_cnt;
    logic               locked;
    logic [IDX_W-1:0]   owner;
    logic [IDX_W-1:0]   rr_ptr;

    logic               lock_expired_c;
    logic [NUM_REQ-1:0] mask_c;
    logic [NUM_REQ-1:0] cand_grant_c;
    logic [IDX_W-1:0]   cand_idx_c;
    logic               cand_found_c;
    logic [7:0]         cand_data_c;
    logic               cand_last_c;
    logic               handshake_c;

    // An abandoned lock is dropped in the very cycle the timeout is reached.
    assign lock_expired_c = (LOCK_TIMEOUT != 0) && locked && (to_cnt == TO_W'(LOCK_TIMEOUT));
    assign mask_c = (locked && !lock_expired_c) ? (NUM_REQ'(1) << owner) : '1;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr (
        .req      (req.req_valid),
        .mask     (mask_c),
        .last_ptr (rr_ptr),
        .grant_c  (cand_grant_c),
        .idx_c    (cand_idx_c),
        .found_c  (cand_found_c)
    );

    // Ready only in IDLE and only to a valid candidate; held low while reset is asserted.
    assign req.req_ready = (sys_rst_ni && (state == ST_IDLE) && cand_found_c) ? cand_grant_c : '0;
    assign handshake_c   = |req.req_ready;

    // Byte and last flag of the current candidate.
    always_comb begin
        cand_data_c = '0;
        cand_last_c = 1'b0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (cand_grant_c[i]) begin
                cand_data_c = req.req_data[8*i +: 8];
                cand_last_c = req.req_last[i];
            end
        end
    end

    // FSM, pacing/timeout counters, lock and registered outputs.
    always_ff @(posedge sys_clk_i) begin
        if (!sys_rst_ni) begin
            state      <= ST_IDLE;
            gap_cnt    <= '0;
            to_cnt     <= '0;
            locked     <= 1'b0;
            owner      <= '0;
            rr_ptr     <= IDX_W'(NUM_REQ - 1);
            uart_wr_o  <= 1'b0;
            uart_dat_o <= '0;
            grant_o    <= '0;
            busy_o     <= 1'b0;
        end else begin
            uart_wr_o <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (handshake_c) begin
                        uart_dat_o <= cand_data_c;
                        grant_o    <= cand_grant_c;
                        rr_ptr     <= cand_idx_c;
                        owner      <= cand_idx_c;
                        locked     <= ~cand_last_c;
                        to_cnt     <= '0;
                        uart_wr_o  <= 1'b1;
                        busy_o     <= 1'b1;
                        state      <= ST_ISSUE;
                    end else if (lock_expired_c) begin
                        locked <= 1'b0;
                        to_cnt <= '0;
                    end else if (locked && (LOCK_TIMEOUT != 0)) begin
                        // Locked with no handshake means the owner is not presenting a byte.
                        to_cnt <= to_cnt + TO_W'(1);
                    end
                end
                ST_ISSUE: begin
                    gap_cnt <= GAP_W'(BYTE_CYCLES - 2);
                    state   <= ST_GAP;
                end
                ST_GAP: begin
                    // Leave as the count reaches zero so IDLE lands exactly BYTE_CYCLES after accept.
                    gap_cnt <= gap_cnt - GAP_W'(1);
                    if (gap_cnt == GAP_W'(1)) begin
                        state  <= ST_IDLE;
                        busy_o <= 1'b0;
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    busy_o <= 1'b0;
                end
            endcase
        end
    end

endmodule
